// File: rtl/lock_pkg.sv
// Shared types and constants for the digital lock (entry and checker sides).
package lock_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 3;
  localparam int PW_W       = 12;

  typedef enum logic [2:0] {
    ENTRY = 3'd0,
    CHECK = 3'd1,
    OPEN  = 3'd2,
    WRONG = 3'd3,
    LOCK  = 3'd4
  } state_e;

  function automatic logic digit_valid(input logic [DIGIT_W-1:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: one-clock pulse on the first cycle a level input is high.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic edge_o
);

  logic sig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig_i;
  end

  assign edge_o = sig_i & ~sig_q;

endmodule

// File: rtl/password_checker.sv
// Unlock side of the digital lock: digit entry, compare, failure count and timed lockout.
// Optional DIGIT_TIMEOUT_EN aborts a partial entry after TIMEOUT_CYCLES idle clocks.
module password_checker
  import lock_pkg::*;
#(
  parameter int MAX_FAIL       = 3,
  parameter int ERR_CYCLES     = 50,
  parameter int LOCK_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [PW_W-1:0] password,
  input  logic [3:0]      mod10,
  input  logic            confirm,
  output logic            unlocked,
  output logic            wrong,
  output logic            locked_out,
  output logic [1:0]      digit_idx,
  output logic [3:0]      fail_cnt
);

  localparam int MAX_AB  = (ERR_CYCLES > LOCK_CYCLES) ? ERR_CYCLES : LOCK_CYCLES;
  localparam int MAX_CYC = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
  localparam int TMR_W   = $clog2(MAX_CYC) + 1;

  state_e            state_q, state_d;
  logic [PW_W-1:0]   buf_q, buf_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        fail_q, fail_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              unlocked_q, unlocked_d;
  logic              wrong_q, wrong_d;
  logic              locked_q, locked_d;
  logic              cedge;
  logic [3:0]        fail_inc;

  edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (confirm),
    .edge_o (cedge)
  );

  assign fail_inc = (fail_q < 4'(MAX_FAIL)) ? fail_q + 4'd1 : fail_q;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    idx_d      = idx_q;
    fail_d     = fail_q;
    timer_d    = timer_q;
    unlocked_d = 1'b0;
    wrong_d    = 1'b0;
    locked_d   = 1'b0;

    case (state_q)
      ENTRY: begin
        if (mode) begin
          buf_d = '0;
          idx_d = '0;
        end else if (cedge && digit_valid(mod10)) begin
          case (idx_q)
            2'd0:    buf_d[PW_W-1 -: DIGIT_W]         = mod10;
            2'd1:    buf_d[PW_W-DIGIT_W-1 -: DIGIT_W] = mod10;
            default: buf_d[DIGIT_W-1:0]               = mod10;
          endcase
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'(NUM_DIGITS - 1)) state_d = CHECK;
`ifdef DIGIT_TIMEOUT_EN
          else timer_d = TMR_W'(TIMEOUT_CYCLES);
`endif
        end
`ifdef DIGIT_TIMEOUT_EN
        // Partial entry left idle: abandon it without counting a failure.
        else if (idx_q != 2'd0) begin
          if (timer_q == '0) begin
            buf_d   = '0;
            idx_d   = '0;
            wrong_d = 1'b1;
          end else begin
            timer_d = timer_q - TMR_W'(1);
          end
        end
`endif
      end

      CHECK: begin
        if (mode) begin
          state_d = ENTRY;
          buf_d   = '0;
          idx_d   = '0;
        end else if (buf_q == password) begin
          state_d = OPEN;
          fail_d  = '0;
        end else begin
          fail_d = fail_inc;
          if (fail_inc == 4'(MAX_FAIL)) begin
            state_d = LOCK;
            timer_d = TMR_W'(LOCK_CYCLES);
          end else begin
            state_d = WRONG;
            timer_d = TMR_W'(ERR_CYCLES);
          end
        end
      end

      OPEN: begin
        if (mode || cedge) begin
          state_d = ENTRY;
          buf_d   = '0;
          idx_d   = '0;
        end else begin
          unlocked_d = 1'b1;
        end
      end

      WRONG: begin
        if (mode || timer_q == '0) begin
          state_d = ENTRY;
          buf_d   = '0;
          idx_d   = '0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
          wrong_d = 1'b1;
        end
      end

      LOCK: begin
        // Lockout cannot be cut short by set mode or by further entry.
        if (timer_q == '0) begin
          state_d = ENTRY;
          buf_d   = '0;
          idx_d   = '0;
          fail_d  = '0;
        end else begin
          timer_d  = timer_q - TMR_W'(1);
          locked_d = 1'b1;
        end
      end

      default: begin
        state_d = ENTRY;
        buf_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ENTRY;
      buf_q      <= '0;
      idx_q      <= '0;
      fail_q     <= '0;
      timer_q    <= '0;
      unlocked_q <= 1'b0;
      wrong_q    <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      idx_q      <= idx_d;
      fail_q     <= fail_d;
      timer_q    <= timer_d;
      unlocked_q <= unlocked_d;
      wrong_q    <= wrong_d;
      locked_q   <= locked_d;
    end
  end

  assign unlocked   = unlocked_q;
  assign wrong      = wrong_q;
  assign locked_out = locked_q;
  assign digit_idx  = idx_q;
  assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_password_checker.sv
// Randomized scoreboard bench for password_checker: attempt-level model, flag-event monitor.
module tb_password_checker;

  localparam int MAX_FAIL       = 3;
  localparam int ERR_CYCLES     = 50;
  localparam int LOCK_CYCLES    = 1000;
  localparam int TIMEOUT_CYCLES = 5000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [11:0] password;
  logic [3:0]  mod10;
  logic        confirm;
  logic        unlocked;
  logic        wrong;
  logic        locked_out;
  logic [1:0]  digit_idx;
  logic [3:0]  fail_cnt;

  password_checker #(
    .MAX_FAIL       (MAX_FAIL),
    .ERR_CYCLES     (ERR_CYCLES),
    .LOCK_CYCLES    (LOCK_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .password   (password),
    .mod10      (mod10),
    .confirm    (confirm),
    .unlocked   (unlocked),
    .wrong      (wrong),
    .locked_out (locked_out),
    .digit_idx  (digit_idx),
    .fail_cnt   (fail_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_OPEN, EV_WRONG, EV_LOCK, EV_TIMEOUT} ev_e;
  typedef struct {
    ev_e kind;
    int  fail;
    int  due;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Attempt-level reference state: stored code and consecutive-failure count.
  logic [11:0] pw;
  int          m_fail;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [3:0] other_digit(input logic [3:0] d);
    return 4'((int'(d) + 1 + int'($urandom_range(0, 8))) % 10);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One confirm edge carrying digit d; s returns the index of the sampling clock.
  task automatic press(input logic [3:0] d, output int s);
    mod10   = d;
    confirm = 1'b1;
    tick(1);
    s       = cyc;
    confirm = 1'b0;
    tick(1);
  endtask

  task automatic push_exp(input ev_e k, input int f, input int due);
    exp_t e;
    e.kind = k;
    e.fail = f;
    e.due  = due;
    q.push_back(e);
  endtask

  task automatic attempt(input logic [11:0] code, input bit relock);
    int s;
    int s2;
    press(code[11:8], s);
    chk("idx_after_1st", int'(digit_idx), 1);
    press(code[7:4], s);
    chk("idx_after_2nd", int'(digit_idx), 2);
    press(code[3:0], s);
    chk("idx_after_3rd", int'(digit_idx), 3);
    if (code == pw) begin
      m_fail = 0;
      push_exp(EV_OPEN, 0, s + 2);
      tick(4);
      chk("open_held", int'(unlocked), 1);
      if (relock) begin
        press(4'($urandom_range(0, 15)), s2);
        chk("relock_unlocked", int'(unlocked), 0);
        chk("relock_idx", int'(digit_idx), 0);
      end
    end else begin
      if (m_fail < MAX_FAIL) m_fail++;
      if (m_fail == MAX_FAIL) begin
        push_exp(EV_LOCK, MAX_FAIL, s + 2);
        tick(3);
        repeat (15) begin
          mode    = 1'($urandom_range(0, 1));
          confirm = 1'($urandom_range(0, 1));
          mod10   = 4'($urandom_range(0, 9));
          tick($urandom_range(1, 20));
        end
        mode    = 1'b0;
        confirm = 1'b0;
        tick(1);
        chk("lock_fail_cnt", int'(fail_cnt), MAX_FAIL);
        chk("lock_held", int'(locked_out), 1);
        while (cyc < s + LOCK_CYCLES + 6) tick(1);
        chk("after_lock_fail_cnt", int'(fail_cnt), 0);
        chk("after_lock_locked", int'(locked_out), 0);
        m_fail = 0;
      end else begin
        push_exp(EV_WRONG, m_fail, s + 2);
        tick(ERR_CYCLES + 6);
        chk("after_wrong_flag", int'(wrong), 0);
        chk("after_wrong_idx", int'(digit_idx), 0);
      end
    end
  endtask

  task automatic new_password(input logic [11:0] p);
    mode = 1'b1;
    tick(1);
    pw       = p;
    password = p;
    tick(1);
    mode = 1'b0;
    tick(1);
  endtask

  // Monitor: every rising flag is matched against the oldest expected event.
  initial begin
    logic pu, pwr, pl;
    exp_t e;
    int   t, len, cls, ecls, elen, f;
    pu = 1'b0; pwr = 1'b0; pl = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pu = 1'b0; pwr = 1'b0; pl = 1'b0;
      end else begin
        cls = -1;
        if (unlocked && !pu)        cls = 0;
        else if (wrong && !pwr)     cls = 1;
        else if (locked_out && !pl) cls = 2;
        if (cls >= 0) begin
          t   = cyc;
          f   = int'(fail_cnt);
          len = 0;
          if (cls != 0) begin
            while (((cls == 1) ? wrong : locked_out) && len < 2000 && !rst) begin
              len++;
              @(negedge clk);
            end
          end
          if (q.size() == 0) begin
            chk("unexpected_event", cls, -1);
          end else begin
            e = q.pop_front();
            case (e.kind)
              EV_OPEN:    begin ecls = 0; elen = 0;           end
              EV_WRONG:   begin ecls = 1; elen = ERR_CYCLES;  end
              EV_LOCK:    begin ecls = 2; elen = LOCK_CYCLES; end
              default:    begin ecls = 1; elen = 1;           end
            endcase
            chk("event_kind", cls, ecls);
            chk("event_latency", t, e.due);
            chk("event_fail_cnt", f, e.fail);
            if (cls != 0) chk("event_length", len, elen);
          end
        end
        pu  = unlocked;
        pwr = wrong;
        pl  = locked_out;
      end
    end
  end

  initial begin
    int s;
    logic [11:0] code;
    int k;

    rst = 1'b1; mode = 1'b0; confirm = 1'b0; mod10 = 4'd0; password = 12'h000;
    pw = 12'h000; m_fail = 0;
    tick(3);
    chk("rst_unlocked", int'(unlocked), 0);
    chk("rst_wrong", int'(wrong), 0);
    chk("rst_locked", int'(locked_out), 0);
    chk("rst_idx", int'(digit_idx), 0);
    chk("rst_fail", int'(fail_cnt), 0);
    rst = 1'b0;
    tick(2);

    new_password(12'h137);
    attempt(12'h137, 1'b1);
    attempt(12'h138, 1'b1);
    attempt(12'h137, 1'b1);
    attempt(12'h237, 1'b1);
    attempt(12'h147, 1'b1);
    attempt(12'h130, 1'b1);
    attempt(12'h137, 1'b1);

    // Out-of-range digit and a confirm held high.
    press(4'hA, s);
    chk("invalid_digit_idx", int'(digit_idx), 0);
    mod10   = 4'd1;
    confirm = 1'b1;
    tick(20);
    confirm = 1'b0;
    tick(1);
    chk("held_confirm_idx", int'(digit_idx), 1);
    press(4'd3, s);
    chk("second_digit_idx", int'(digit_idx), 2);
    mode = 1'b1;
    tick(1);
    chk("mode_clears_idx", int'(digit_idx), 0);
    mode = 1'b0;
    tick(1);

    // Idle partial entry, with one failure already on record.
    attempt(12'h100, 1'b1);
    press(4'd1, s);
    chk("timeout_start_idx", int'(digit_idx), 1);
`ifdef DIGIT_TIMEOUT_EN
    push_exp(EV_TIMEOUT, m_fail, s + TIMEOUT_CYCLES + 1);
    tick(TIMEOUT_CYCLES + 10);
    chk("timeout_idx", int'(digit_idx), 0);
`else
    tick(TIMEOUT_CYCLES + 10);
    chk("no_timeout_idx", int'(digit_idx), 1);
    mode = 1'b1;
    tick(1);
    mode = 1'b0;
    tick(1);
`endif
    chk("timeout_fail_kept", int'(fail_cnt), m_fail);

    repeat (10) begin
      new_password({4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))});
      code = pw;
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, 2);
        case (k)
          0:       code[11:8] = other_digit(pw[11:8]);
          1:       code[7:4]  = other_digit(pw[7:4]);
          default: code[3:0]  = other_digit(pw[3:0]);
        endcase
      end
      attempt(code, 1'b1);
    end

    // Asynchronous reset while open.
    attempt(pw, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_unlocked", int'(unlocked), 0);
    chk("async_rst_idx", int'(digit_idx), 0);
    chk("async_rst_fail", int'(fail_cnt), 0);
    tick(1);
    rst = 1'b0;
    m_fail = 0;
    tick(5);
    chk("queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
